ebi_master: RTL and testbench
=============================

// Module: ebi_master
// PURPOSE
//  Initiator side of the 16-bit SRAM-style external bus (addr/data/cs/rd/wr, strobes active-low) used between the AT91SAM9 SMC and the FPGA.
//  Converts a single-beat valid/ready request into a bus cycle with programmable setup/pulse/hold/turnaround phases.
//  Returns read data, or a write acknowledge, on a one-cycle response strobe.
//  Used for FPGA-driven access to external SRAM-style peripherals and as the bus driver in the loopback bench of the FPGA bus slave.
// PARAMETERS
//  ADDR_WIDTH    25  bus address width (byte address, LSB driven as issued)
//  DATA_WIDTH    16  bus data width
//  SETUP_CYCLES  2   cs_n low, strobes high, before strobe assertion (1..15)
//  PULSE_CYCLES  4   rd_n/wr_n low duration (1..15)
//  HOLD_CYCLES   2   strobes high, cs_n still low, addr/data held (1..15)
//  TURN_CYCLES   1   cs_n high, data_oe low, before next request (0..15; 0 = phase skipped)
// PORTS
//  clk_i        in   1           system clock
//  reset_i      in   1           asynchronous, active-high reset
//  req_valid_i  in   1           request present
//  req_ready_o  out  1           request accepted when valid&&ready
//  req_we_i     in   1           1 = write, 0 = read
//  req_addr_i   in   ADDR_WIDTH  request address
//  req_wdata_i  in   DATA_WIDTH  write data
//  resp_valid_o out  1           one-cycle completion strobe (read and write)
//  resp_rdata_o out  DATA_WIDTH  read data, valid with resp_valid_o; held until next read
//  busy_o       out  1           high in any state other than IDLE
//  bus_addr_o   out  ADDR_WIDTH  external address bus
//  bus_data_o   out  DATA_WIDTH  data to pad IOBUF .I
//  bus_data_i   in   DATA_WIDTH  data from pad IOBUF .O
//  bus_data_oe_o out 1           1 = FPGA drives data pads (IOBUF .T = !oe)
//  bus_cs_n_o   out  1           chip select, active-low
//  bus_rd_n_o   out  1           read strobe, active-low
//  bus_wr_n_o   out  1           write strobe, active-low
// BEHAVIOUR
//  - Reset (async, immediate): cs_n/rd_n/wr_n = 1, data_oe = 0, addr/data_o/rdata = 0, resp_valid = 0, busy = 0, state = IDLE; an in-flight cycle is abandoned, no response issued.
//  - All bus outputs are registered; no combinational path from req_* to bus_*.
//  - FSM: IDLE -> SETUP -> PULSE -> HOLD -> TURN -> IDLE; TURN skipped when TURN_CYCLES = 0.
//  - IDLE: req_ready = 1. On valid&&ready at edge T0, latch we/addr/wdata; enter SETUP at T0 (cs_n falls, addr valid, data_oe = we).
//  - Each phase lasts exactly its parameter in clocks, timed by a down-counter loaded on phase entry.
//  - PULSE: rd_n (read) or wr_n (write) low; addr/data/cs_n stable for the whole phase.
//  - Read sample: bus_data_i captured into resp_rdata_o on the edge that ends PULSE (rd_n still low at capture).
//  - HOLD entry: rd_n/wr_n return high; resp_valid_o high for exactly the first HOLD cycle.
//  - HOLD end: cs_n high. TURN: data_oe = 0, addr held.
//  - req_ready_o = 0 outside IDLE; requests presented while busy wait (valid must stay high, request fields stable).
//  - Throughput: one transaction per SETUP+PULSE+HOLD+TURN+1 clocks (defaults: 10).
//  - Read cycles: data_oe stays 0 throughout. Write cycles: data_oe = 1 from SETUP through HOLD.
//  - bus_addr_o / bus_data_o keep the last values in IDLE (no glitching to 0).
//  - Only one rd_n/wr_n is ever low; both are high whenever cs_n is high.
//  - Parameter values outside the legal range are a configuration error; elaboration-time check reports it.
// STRUCTURE
//  - Shared package ebi_pkg: state encoding (IDLE/SETUP/PULSE/HOLD/TURN, 3 bits), phase counter width (4), default widths (25/16).
//    The FPGA bus slave uses the same package.
//  - Sub-module ebi_phase_timer: 4-bit loadable down-counter; load_i/value_i, done_o when count = 1 or loaded 1.
//  - IOBUF instantiation stays at top level, outside this block.
// TESTING
//  - Write, defaults: addr 0x2004, wdata 0xA5C3.
//    -> cs_n low 8 clks; wr_n low exactly clks 3-6 after accept; data_oe 1 for 8 clks; resp_valid 1 clk; ready again 10 clks after accept.
//  - Read, defaults: pad model returns 0x1234 only during wr/rd pulse, addr 0x2006.
//    -> resp_rdata = 0x1234 with resp_valid; data_oe never 1.
//  - Back-to-back: req_valid held with 3 requests (W 0x2000, R 0x2000, W 0x2002).
//    -> three non-overlapping cycles 10 clks apart; TURN gap (cs_n high, oe 0) of 1 clk between each; accept order preserved.
//  - Min timing: SETUP=PULSE=HOLD=1, TURN=0, read.
//    -> 3-clk cycle; sample on the single pulse cycle; ready on 4th clk.
//  - Reset mid-PULSE of a write: assert reset_i asynchronously.
//    -> wr_n/cs_n high and oe 0 before the next edge; no resp_valid; first request after release runs normally.
//  - Bus checker throughout: rd_n and wr_n never both low; no strobe low while cs_n high; addr stable while cs_n low.

Source files
------------

// File: rtl/ebi_pkg.sv
// Shared definitions for the 16-bit SRAM-style external bus: FSM state encoding,
// phase counter width and default bus widths. Also used by the FPGA-side bus slave.
package ebi_pkg;

    localparam int STATE_W    = 3;
    localparam int PH_W       = 4;
    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 16;
    localparam int PH_MAX     = (1 << PH_W) - 1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_TURN  = 3'd4
    } ebi_state_e;

    // True when a phase length fits the counter and respects its lower bound.
    function automatic bit phase_ok(input int value, input int min_value);
        return (value >= min_value) && (value <= PH_MAX);
    endfunction

endpackage

// File: rtl/ebi_master_if.sv
// External bus pins as seen from the FPGA: address, split data (pad IOBUF I/O/T),
// and the active-low chip select and strobes.
interface ebi_master_if #(
    parameter int ADDR_WIDTH = ebi_pkg::DEF_ADDR_W,
    parameter int DATA_WIDTH = ebi_pkg::DEF_DATA_W
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_oe;
    logic                  cs_n;
    logic                  rd_n;
    logic                  wr_n;

    modport master (
        output addr, data_out, data_oe, cs_n, rd_n, wr_n,
        input  data_in
    );

    modport slave (
        input  addr, data_out, data_oe, cs_n, rd_n, wr_n,
        output data_in
    );
endinterface

// File: rtl/ebi_phase_timer.sv
// Loadable down-counter timing one bus phase; done_o flags the last cycle of the phase.
module ebi_phase_timer
    import ebi_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [PH_W-1:0] value_i,
    output logic            done_o
);

    logic [PH_W-1:0] count_reg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_reg <= '0;
        end else if (load_i) begin
            count_reg <= value_i;
        end else if (count_reg > PH_W'(1)) begin
            count_reg <= count_reg - PH_W'(1);
        end
    end

    assign done_o = (count_reg == PH_W'(1));

endmodule

// File: rtl/ebi_master.sv
// Initiator for the SRAM-style external bus: turns one accepted request into a
// SETUP/PULSE/HOLD/TURN bus cycle and returns a one-cycle completion strobe.
module ebi_master
    import ebi_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_W,
    parameter int DATA_WIDTH   = DEF_DATA_W,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 2,
    parameter int TURN_CYCLES  = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  busy_o,
    ebi_master_if.master          bus
);

    if (!phase_ok(SETUP_CYCLES, 1) || !phase_ok(PULSE_CYCLES, 1) ||
        !phase_ok(HOLD_CYCLES, 1)  || !phase_ok(TURN_CYCLES, 0)) begin : g_bad_cfg
        $error("ebi_master: phase length parameter out of range");
    end

    ebi_state_e            state_reg, state_next;
    logic                  we_reg, we_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] data_out_reg, data_out_next;
    logic                  oe_reg, oe_next;
    logic                  cs_n_reg, cs_n_next;
    logic                  rd_n_reg, rd_n_next;
    logic                  wr_n_reg, wr_n_next;
    logic                  resp_valid_reg, resp_valid_next;
    logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;

    logic                  timer_load;
    logic [PH_W-1:0]       timer_value;
    logic                  phase_done;

    ebi_phase_timer u_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (timer_load),
        .value_i (timer_value),
        .done_o  (phase_done)
    );

    // Every bus pin is computed one cycle ahead and registered, so the pads never
    // see a combinational path from the request side.
    always_comb begin
        state_next      = state_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        data_out_next   = data_out_reg;
        oe_next         = oe_reg;
        cs_n_next       = cs_n_reg;
        rd_n_next       = rd_n_reg;
        wr_n_next       = wr_n_reg;
        rdata_next      = rdata_reg;
        resp_valid_next = 1'b0;
        timer_load      = 1'b0;
        timer_value     = PH_W'(SETUP_CYCLES);

        case (state_reg)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_next  = ST_SETUP;
                    timer_load  = 1'b1;
                    timer_value = PH_W'(SETUP_CYCLES);
                    we_next     = req_we_i;
                    addr_next   = req_addr_i;
                    cs_n_next   = 1'b0;
                    oe_next     = req_we_i;
                    if (req_we_i) begin
                        data_out_next = req_wdata_i;
                    end
                end
            end

            ST_SETUP: begin
                if (phase_done) begin
                    state_next  = ST_PULSE;
                    timer_load  = 1'b1;
                    timer_value = PH_W'(PULSE_CYCLES);
                    rd_n_next   = we_reg;
                    wr_n_next   = !we_reg;
                end
            end

            ST_PULSE: begin
                if (phase_done) begin
                    // This edge still sees rd_n low at the pads, so data_in is the slave's word.
                    state_next      = ST_HOLD;
                    timer_load      = 1'b1;
                    timer_value     = PH_W'(HOLD_CYCLES);
                    rd_n_next       = 1'b1;
                    wr_n_next       = 1'b1;
                    resp_valid_next = 1'b1;
                    if (!we_reg) begin
                        rdata_next = bus.data_in;
                    end
                end
            end

            ST_HOLD: begin
                if (phase_done) begin
                    cs_n_next = 1'b1;
                    oe_next   = 1'b0;
                    if (TURN_CYCLES == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next  = ST_TURN;
                        timer_load  = 1'b1;
                        timer_value = PH_W'(TURN_CYCLES);
                    end
                end
            end

            ST_TURN: begin
                if (phase_done) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cs_n_next  = 1'b1;
                rd_n_next  = 1'b1;
                wr_n_next  = 1'b1;
                oe_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= ST_IDLE;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            data_out_reg   <= '0;
            oe_reg         <= 1'b0;
            cs_n_reg       <= 1'b1;
            rd_n_reg       <= 1'b1;
            wr_n_reg       <= 1'b1;
            resp_valid_reg <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            data_out_reg   <= data_out_next;
            oe_reg         <= oe_next;
            cs_n_reg       <= cs_n_next;
            rd_n_reg       <= rd_n_next;
            wr_n_reg       <= wr_n_next;
            resp_valid_reg <= resp_valid_next;
            rdata_reg      <= rdata_next;
        end
    end

    assign req_ready_o  = (state_reg == ST_IDLE);
    assign busy_o       = (state_reg != ST_IDLE);
    assign resp_valid_o = resp_valid_reg;
    assign resp_rdata_o = rdata_reg;

    assign bus.addr     = addr_reg;
    assign bus.data_out = data_out_reg;
    assign bus.data_oe  = oe_reg;
    assign bus.cs_n     = cs_n_reg;
    assign bus.rd_n     = rd_n_reg;
    assign bus.wr_n     = wr_n_reg;

endmodule

// File: tb/tb_ebi_master.sv
// Bench for ebi_master: default-timing and minimum-timing instances run the same
// request table against an SRAM pad model, with a scoreboard and a bus-phase monitor.
module tb_ebi_master;
    import ebi_pkg::*;

    localparam int AW    = 25;
    localparam int DW    = 16;
    localparam int N_DUT = 2;
    localparam int N_STIM = 10;
    localparam int S_CYC [N_DUT] = '{2, 1};
    localparam int P_CYC [N_DUT] = '{4, 1};
    localparam int H_CYC [N_DUT] = '{2, 1};
    localparam int T_CYC [N_DUT] = '{1, 0};

    // kind: 0 = read, 1 = write, 2 = write abandoned by reset mid-pulse
    typedef struct {
        int              kind;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        bit              hold;
    } stim_t;

    typedef struct {
        bit            we;
        logic [DW-1:0] data;
        logic [3:0]    idx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input int inst, input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL i%0d %s: got %0h expected %0h (t=%0t)", inst, tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 3) ? 16'h1234 : (16'hC000 | 16'(i));
    endfunction

    function automatic stim_t get_stim(input int n);
        stim_t s;
        case (n)
            0: s = '{1, 25'h2004, 16'hA5C3, 1'b0};
            1: s = '{0, 25'h2006, 16'h0000, 1'b0};
            2: s = '{1, 25'h2000, 16'h5A01, 1'b1};
            3: s = '{0, 25'h2000, 16'h0000, 1'b1};
            4: s = '{1, 25'h2002, 16'h0F0F, 1'b0};
            5: s = '{0, 25'h2002, 16'h0000, 1'b0};
            6: s = '{2, 25'h201E, 16'hBEEF, 1'b0};
            7: s = '{0, 25'h2004, 16'h0000, 1'b0};
            8: s = '{1, 25'h2008, 16'h3C96, 1'b1};
            default: s = '{0, 25'h2008, 16'h0000, 1'b0};
        endcase
        return s;
    endfunction

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        localparam int S   = S_CYC[gi];
        localparam int P   = P_CYC[gi];
        localparam int H   = H_CYC[gi];
        localparam int T   = T_CYC[gi];
        localparam int TOT = S + P + H + T + 1;

        logic          rst;
        logic          req_valid, req_ready, req_we;
        logic [AW-1:0] req_addr;
        logic [DW-1:0] req_wdata;
        logic          resp_valid, busy;
        logic [DW-1:0] resp_rdata;
        bit            done_flag = 1'b0;

        ebi_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

        ebi_master #(
            .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H), .TURN_CYCLES(T)
        ) dut (
            .clk_i        (clk),
            .reset_i      (rst),
            .req_valid_i  (req_valid),
            .req_ready_o  (req_ready),
            .req_we_i     (req_we),
            .req_addr_i   (req_addr),
            .req_wdata_i  (req_wdata),
            .resp_valid_o (resp_valid),
            .resp_rdata_o (resp_rdata),
            .busy_o       (busy),
            .bus          (bus)
        );

        // SRAM pad model: drives its word only while a read strobe is active.
        logic [DW-1:0] pad_mem [16];
        assign bus.data_in = (!bus.cs_n && !bus.rd_n) ? pad_mem[bus.addr[4:1]] : 16'hDEAD;

        initial begin
            for (int i = 0; i < 16; i++) pad_mem[i] = init_word(i);
            forever begin
                @(posedge clk);
                if (!bus.cs_n && !bus.wr_n && bus.data_oe) pad_mem[bus.addr[4:1]] = bus.data_out;
            end
        end

        exp_t          sb_q[$];
        logic [DW-1:0] shadow [16];

        // Monitor: bus rules every cycle, scoreboard on responses, phase timing per transaction.
        bit            in_txn = 1'b0;
        bit            mon_we;
        int            acc_cyc, k, cs_cnt, stb_first, stb_last, stb_cnt, wrong_cnt, oe_cnt, resp_cnt, resp_k;
        logic          prev_cs_n = 1'b1;
        logic [AW-1:0] prev_addr;
        exp_t          e;

        always @(negedge clk) begin
            if (rst) begin
                in_txn    = 1'b0;
                prev_cs_n = 1'b1;
            end else begin
                check(gi, "strobe_excl", {31'b0, bus.rd_n | bus.wr_n}, 32'd1);
                if (bus.cs_n) check(gi, "strobe_while_cs_high", {31'b0, bus.rd_n & bus.wr_n}, 32'd1);
                if (!bus.cs_n && !prev_cs_n) check(gi, "addr_stable", bus.addr, prev_addr);
                prev_cs_n = bus.cs_n;
                prev_addr = bus.addr;

                if (resp_valid) begin
                    if (sb_q.size() == 0) begin
                        check(gi, "resp_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.we) check(gi, "pad_wdata", pad_mem[e.idx], e.data);
                        else      check(gi, "rdata", resp_rdata, e.data);
                    end
                end

                if (in_txn && cyc >= acc_cyc) begin
                    k = cyc - acc_cyc + 1;
                    if (!bus.cs_n) cs_cnt++;
                    if (mon_we ? !bus.wr_n : !bus.rd_n) begin
                        if (stb_first == 0) stb_first = k;
                        stb_last = k;
                        stb_cnt++;
                    end
                    if (mon_we ? !bus.rd_n : !bus.wr_n) wrong_cnt++;
                    if (bus.data_oe) oe_cnt++;
                    if (resp_valid) begin
                        resp_cnt++;
                        resp_k = k;
                    end
                    if (req_ready) begin
                        check(gi, "ready_cycle", k, TOT);
                        check(gi, "cs_low_cycles", cs_cnt, S + P + H);
                        check(gi, "strobe_first", stb_first, S + 1);
                        check(gi, "strobe_last", stb_last, S + P);
                        check(gi, "strobe_cycles", stb_cnt, P);
                        check(gi, "wrong_strobe", wrong_cnt, 0);
                        check(gi, "oe_cycles", oe_cnt, mon_we ? S + P + H : 0);
                        check(gi, "resp_count", resp_cnt, 1);
                        check(gi, "resp_cycle", resp_k, S + P + 1);
                        in_txn = 1'b0;
                    end
                end

                if (req_valid && req_ready) begin
                    in_txn    = 1'b1;
                    acc_cyc   = cyc + 1;
                    mon_we    = req_we;
                    cs_cnt    = 0;
                    stb_first = 0;
                    stb_last  = 0;
                    stb_cnt   = 0;
                    wrong_cnt = 0;
                    oe_cnt    = 0;
                    resp_cnt  = 0;
                    resp_k    = 0;
                end
            end
        end

        // Driver: walks the request table, pushes expectations on acceptance.
        initial begin
            stim_t s;
            int    waited, acc, prev_acc;
            bit    prev_hold;
            for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
            rst       = 1'b1;
            req_valid = 1'b0;
            req_we    = 1'b0;
            req_addr  = '0;
            req_wdata = '0;
            repeat (2) @(negedge clk);
            check(gi, "rst_cs_n", bus.cs_n, 1);
            check(gi, "rst_rd_n", bus.rd_n, 1);
            check(gi, "rst_wr_n", bus.wr_n, 1);
            check(gi, "rst_oe", bus.data_oe, 0);
            check(gi, "rst_addr", bus.addr, 0);
            check(gi, "rst_data", bus.data_out, 0);
            check(gi, "rst_rdata", resp_rdata, 0);
            check(gi, "rst_resp", resp_valid, 0);
            check(gi, "rst_busy", busy, 0);
            rst = 1'b0;
            @(negedge clk);
            prev_acc  = 0;
            prev_hold = 1'b0;

            for (int n = 0; n < N_STIM; n++) begin
                s         = get_stim(n);
                req_valid = 1'b1;
                req_we    = (s.kind != 0);
                req_addr  = s.addr;
                req_wdata = s.data;
                waited    = 0;
                while (!req_ready && waited < 64) begin
                    @(negedge clk);
                    waited++;
                end
                if (!req_ready) begin
                    check(gi, "accept_timeout", 32'd0, 32'd1);
                    break;
                end
                @(posedge clk);
                #1;
                acc = cyc;
                if (prev_hold) check(gi, "b2b_spacing", acc - prev_acc, TOT);
                if (s.kind == 1) begin
                    shadow[s.addr[4:1]] = s.data;
                    sb_q.push_back('{1'b1, s.data, s.addr[4:1]});
                end else if (s.kind == 0) begin
                    sb_q.push_back('{1'b0, shadow[s.addr[4:1]], s.addr[4:1]});
                end
                $display("i%0d txn %0d: %s addr=%h wdata=%h accepted at cycle %0d",
                         gi, n, (s.kind == 0) ? "RD" : "WR", s.addr, s.data, acc);
                prev_acc  = acc;
                prev_hold = s.hold;
                if (!s.hold) req_valid = 1'b0;

                if (s.kind == 2) begin
                    waited = 0;
                    while (bus.wr_n && waited < 64) begin
                        @(negedge clk);
                        waited++;
                    end
                    check(gi, "reset_reach_pulse", bus.wr_n, 0);
                    #1 rst = 1'b1;
                    #1;
                    check(gi, "arst_wr_n", bus.wr_n, 1);
                    check(gi, "arst_cs_n", bus.cs_n, 1);
                    check(gi, "arst_oe", bus.data_oe, 0);
                    check(gi, "arst_busy", busy, 0);
                    repeat (2) @(negedge clk);
                    rst       = 1'b0;
                    prev_hold = 1'b0;
                end else if (!s.hold) begin
                    waited = 0;
                    while (sb_q.size() != 0 && waited < 64) begin
                        @(negedge clk);
                        waited++;
                    end
                    check(gi, "resp_timeout", sb_q.size(), 0);
                    @(negedge clk);
                end
            end

            waited = 0;
            while ((sb_q.size() != 0 || busy) && waited < 64) begin
                @(negedge clk);
                waited++;
            end
            check(gi, "drain", sb_q.size(), 0);
            done_flag = 1'b1;
        end
    end

    initial begin
        int w;
        w = 0;
        while (!(g_dut[0].done_flag && g_dut[1].done_flag) && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (!(g_dut[0].done_flag && g_dut[1].done_flag)) check(-1, "sim_timeout", 32'd0, 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
